// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared constants and helpers for the keypad scanner. Holds
//               the default matrix size, the function-key codes and the
//               code-to-digit map for the 4x4 keypad layout.
//               Key codes are row*COLS+col.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int DEFAULT_ROWS = 4;
  localparam int DEFAULT_COLS = 4;

  localparam int KEY_CLR   = 12;
  localparam int KEY_ENTER = 15;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] bcd;
  } digit_t;

  // Codes 7, 11, 13 and 14 are reserved. They map to is_digit=0, and so do
  // CLR and ENTER.
  function automatic digit_t key_to_digit(input logic [7:0] code);
    digit_t d;
    d.is_digit = 1'b1;
    d.bcd      = 4'd0;
    case (code)
      8'd0:    d.bcd = 4'd1;
      8'd4:    d.bcd = 4'd2;
      8'd8:    d.bcd = 4'd3;
      8'd1:    d.bcd = 4'd4;
      8'd5:    d.bcd = 4'd5;
      8'd9:    d.bcd = 4'd6;
      8'd2:    d.bcd = 4'd7;
      8'd6:    d.bcd = 4'd8;
      8'd10:   d.bcd = 4'd9;
      8'd3:    d.bcd = 4'd0;
      default: d.is_digit = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Frame-level debounce and single-key event detection.
//               At each frame end the raw frame is compared with the
//               previous frame. After DEBOUNCE identical frames the
//               debounced image takes the raw frame. A press event fires
//               when the image goes from empty to exactly one key.
// Ports       : clk, reset (async, active-low)
//               frame_end  - raw_frame is complete this cycle
//               raw_frame  - frame bits, column-major (col*ROWS + row)
//               key_valid  - one-clk event pulse
//               key_code   - row*COLS+col of the last event
//               multi_key  - debounced image holds 2 or more keys
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_end,
  input  logic [ROWS*COLS-1:0]         raw_frame,
  output logic                         key_valid,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         multi_key
);

  localparam int c_N  = ROWS * COLS;
  localparam int c_CW = $clog2(ROWS * COLS);
  localparam int c_SW = $clog2(DEBOUNCE + 1);

  logic [c_N-1:0]  r_prev;
  logic [c_N-1:0]  r_image;
  logic [c_SW-1:0] r_stable;
  logic [c_SW-1:0] w_stable_next;
  logic            w_update;
  logic            w_press;
  logic [c_CW-1:0] w_raw_code;
  logic            r_key_valid;
  logic [c_CW-1:0] r_key_code;

  function automatic int popcnt(input logic [c_N-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < c_N; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // A changed frame restarts the count at 1: the new frame is itself the
  // first stable observation.
  always_comb begin
    if (raw_frame == r_prev) begin
      w_stable_next = (r_stable == c_SW'(DEBOUNCE)) ? r_stable : r_stable + 1'b1;
    end else begin
      w_stable_next = c_SW'(1);
    end
  end

  assign w_update = frame_end && (w_stable_next == c_SW'(DEBOUNCE));

  // Only a press from an empty image counts, so holds and roll-overs
  // produce no repeats.
  assign w_press = w_update && (popcnt(raw_frame) == 1) && (r_image == '0);

  // Frame bit index is col*ROWS+row; the reported code is row*COLS+col.
  always_comb begin
    w_raw_code = '0;
    for (int i = 0; i < c_N; i++) begin
      if (raw_frame[i]) w_raw_code = c_CW'((i % ROWS) * COLS + i / ROWS);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev      <= '0;
      r_image     <= '0;
      r_stable    <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_key_valid <= w_press;
      if (w_press) r_key_code <= w_raw_code;
      if (frame_end) begin
        r_prev   <= raw_frame;
        r_stable <= w_stable_next;
      end
      if (w_update) r_image <= raw_frame;
    end
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign multi_key = (popcnt(r_image) >= 2);

endmodule
`default_nettype wire

// File: rtl/keypad_scan_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_entry
// Description : Matrix keypad scanner with debounce, single-key events and
//               a DIGITS-wide BCD entry register committed by ENTER.
// Ports       : clk, reset (async, active-low)
//               key_in      - row sense lines, active-high
//               key_out     - one-hot column drive
//               key_valid   - one-clk debounced key press pulse
//               key_code    - code of last event (row*COLS+col)
//               multi_key   - 2 or more keys held in the debounced image
//               entry_bcd   - live entry digits, LS digit in [3:0]
//               entry_cnt   - number of digits entered
//               entry_value - last committed entry
//               entry_done  - one-clk pulse when entry_value loads
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int COLS     = DEFAULT_COLS,
  parameter int ROWS     = DEFAULT_ROWS,
  parameter int TICK_DIV = 30000,
  parameter int DEBOUNCE = 3,
  parameter int DIGITS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS-1:0]              key_in,
  output logic [COLS-1:0]              key_out,
  output logic                         key_valid,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         multi_key,
  output logic [4*DIGITS-1:0]          entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  entry_cnt,
  output logic [4*DIGITS-1:0]          entry_value,
  output logic                         entry_done
);

  localparam int c_CW    = $clog2(ROWS * COLS);
  localparam int c_BW    = 4 * DIGITS;
  localparam int c_NW    = $clog2(DIGITS + 1);
  localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_CIX_W = (COLS > 1) ? $clog2(COLS) : 1;

  // ---------------- scan-step divider ----------------
  logic [c_DIV_W-1:0] r_div;
  logic               w_tick;

  assign w_tick = (r_div == c_DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // ---------------- column drive and frame capture ----------------
  logic [COLS-1:0]      r_col;
  logic [COLS-1:0]      w_col_next;
  logic                 w_col_legal;
  logic [c_CIX_W-1:0]   w_col_idx;
  logic [ROWS*COLS-1:0] r_frame;
  logic [ROWS*COLS-1:0] w_frame_next;
  logic                 w_frame_end;

  assign w_col_legal = $onehot(r_col);

  always_comb begin
    w_col_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (r_col[c]) w_col_idx = c_CIX_W'(c);
    end
  end

  // A corrupted column register restarts the scan at column 0; no sample is
  // taken on that tick because the driven column is unknown.
  always_comb begin
    if (w_col_legal) w_col_next = (r_col << 1) | (r_col >> (COLS - 1));
    else             w_col_next = COLS'(1);
  end

  // The frame seen at frame end includes the column sampled on that tick.
  always_comb begin
    w_frame_next = r_frame;
    if (w_col_legal) w_frame_next[int'(w_col_idx)*ROWS +: ROWS] = key_in;
  end

  assign w_frame_end = w_tick && w_col_legal && r_col[COLS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col   <= COLS'(1);
      r_frame <= '0;
    end else if (w_tick) begin
      r_col   <= w_col_next;
      r_frame <= w_frame_next;
    end
  end

  assign key_out = r_col;

  // ---------------- debounce / event detection ----------------
  logic            w_key_valid;
  logic [c_CW-1:0] w_key_code;

  keypad_debounce #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .frame_end (w_frame_end),
    .raw_frame (w_frame_next),
    .key_valid (w_key_valid),
    .key_code  (w_key_code),
    .multi_key (multi_key)
  );

  assign key_valid = w_key_valid;
  assign key_code  = w_key_code;

  // ---------------- entry register ----------------
  digit_t          w_digit;
  logic [c_BW-1:0] r_bcd;
  logic [c_NW-1:0] r_cnt;
  logic [c_BW-1:0] r_value;
  logic            r_done;

  assign w_digit = key_to_digit(8'(w_key_code));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_key_valid) begin
        if (w_digit.is_digit) begin
          // A full entry silently drops further digits.
          if (r_cnt < c_NW'(DIGITS)) begin
            r_bcd <= (r_bcd << 4) | c_BW'(w_digit.bcd);
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (w_key_code == c_CW'(KEY_ENTER)) begin
          if (r_cnt != '0) begin
            r_value <= r_bcd;
            r_done  <= 1'b1;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end else if (w_key_code == c_CW'(KEY_CLR)) begin
          r_bcd <= '0;
          r_cnt <= '0;
        end
      end
    end
  end

  assign entry_bcd   = r_bcd;
  assign entry_cnt   = r_cnt;
  assign entry_value = r_value;
  assign entry_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_entry
// Description : Self-checking bench for keypad_scan_entry with a small
//               keypad model driving the row lines from the column strobes,
//               a frame-level reference model and directed key sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_entry;

  localparam int COLS     = 4;
  localparam int ROWS     = 4;
  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int DIGITS   = 2;
  localparam int NK       = ROWS * COLS;
  localparam int FRAME    = COLS * TICK_DIV;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [ROWS-1:0] key_in;
  logic [COLS-1:0] key_out;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            multi_key;
  logic [7:0]      entry_bcd;
  logic [1:0]      entry_cnt;
  logic [7:0]      entry_value;
  logic            entry_done;

  logic [NK-1:0]   pressed = '0;   // indexed by key code row*COLS+col

  int vectors = 0;
  int errors  = 0;
  int n_valid = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  keypad_scan_entry #(
    .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK_DIV),
    .DEBOUNCE(DEBOUNCE), .DIGITS(DIGITS)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_out(key_out),
    .key_valid(key_valid), .key_code(key_code), .multi_key(multi_key),
    .entry_bcd(entry_bcd), .entry_cnt(entry_cnt),
    .entry_value(entry_value), .entry_done(entry_done)
  );

  // Physical keypad: a held key connects its column strobe to its row.
  always_comb begin
    key_in = '0;
    for (int c = 0; c < COLS; c++)
      if (key_out[c])
        for (int r = 0; r < ROWS; r++)
          if (pressed[r*COLS+c]) key_in[r] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            digit_of [NK] = '{1, 4, 7, 0, 2, 5, 8, -1, 3, 6, 9, -1, -1, -1, -1, -1};
  int            m_k;
  logic [NK-1:0] m_raw, m_image;
  logic [NK-1:0] hist[$];
  int            m_key_out, m_key_code, m_bcd, m_cnt, m_value;
  bit            m_key_valid, m_done;

  task automatic model_reset();
    m_k = 0; m_raw = '0; m_image = '0; hist.delete();
    m_key_out = 1; m_key_code = 0; m_bcd = 0; m_cnt = 0; m_value = 0;
    m_key_valid = 0; m_done = 0;
  endtask

  task automatic model_step();
    int col, d;
    bit same;
    m_done = 0;
    if (m_key_valid) begin
      d = digit_of[m_key_code];
      if (d >= 0) begin
        if (m_cnt < DIGITS) begin
          m_bcd = ((m_bcd * 16) + d) % (1 << (4*DIGITS));
          m_cnt++;
        end
      end else if (m_key_code == 15) begin
        if (m_cnt > 0) begin
          m_value = m_bcd; m_done = 1; m_bcd = 0; m_cnt = 0;
        end
      end else if (m_key_code == 12) begin
        m_bcd = 0; m_cnt = 0;
      end
    end
    m_key_valid = 0;
    m_k++;
    if (m_k % TICK_DIV == 0) begin
      col = ((m_k / TICK_DIV) - 1) % COLS;
      for (int r = 0; r < ROWS; r++) m_raw[r*COLS+col] = pressed[r*COLS+col];
      if (col == COLS - 1) begin
        hist.push_back(m_raw);
        if (hist.size() > DEBOUNCE) hist.delete(0);
        same = (hist.size() == DEBOUNCE);
        foreach (hist[i]) if (hist[i] != m_raw) same = 0;
        if (same) begin
          if ($countones(m_raw) == 1 && m_image == '0) begin
            m_key_valid = 1;
            for (int i = 0; i < NK; i++) if (m_raw[i]) m_key_code = i;
          end
          m_image = m_raw;
        end
      end
    end
    m_key_out = 1 << ((m_k / TICK_DIV) % COLS);
  endtask

  always @(posedge clk) begin
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("key_out",     key_out,     m_key_out);
    check("key_valid",   key_valid,   m_key_valid);
    check("key_code",    key_code,    m_key_code);
    check("multi_key",   multi_key,   ($countones(m_image) >= 2));
    check("entry_bcd",   entry_bcd,   m_bcd);
    check("entry_cnt",   entry_cnt,   m_cnt);
    check("entry_value", entry_value, m_value);
    check("entry_done",  entry_done,  m_done);
    if (key_valid)  n_valid++;
    if (entry_done) n_done++;
  end

  // ---------------- stimulus ----------------
  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic press_key(input int code);
    @(negedge clk) pressed = '0;
    pressed[code] = 1'b1;
    wait_frames(5);
    pressed = '0;
    wait_frames(5);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_out"},   key_out,     4'b0001);
    check({tag, "_valid"},     key_valid,   0);
    check({tag, "_code"},      key_code,    0);
    check({tag, "_multi"},     multi_key,   0);
    check({tag, "_bcd"},       entry_bcd,   0);
    check({tag, "_cnt"},       entry_cnt,   0);
    check({tag, "_value"},     entry_value, 0);
    check({tag, "_done"},      entry_done,  0);
  endtask

  int v0, d0;

  initial begin
    // Reset state and scan sequence with no keys
    repeat (3) @(negedge clk);
    #1 check_reset_values("rst");
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk); #1 check("scan_c0", key_out, 4'b0001);
    @(posedge clk);            #1 check("scan_c1", key_out, 4'b0010);
    repeat (4) @(posedge clk); #1 check("scan_c2", key_out, 4'b0100);
    repeat (4) @(posedge clk); #1 check("scan_c3", key_out, 4'b1000);
    repeat (4) @(posedge clk); #1 check("scan_wrap", key_out, 4'b0001);
    wait_frames(4);
    check("idle_no_event", n_valid, 0);

    // Key 5 held from reset release: event at end of frame 3, no repeats
    @(negedge clk) reset = 1'b0;
    pressed = '0; pressed[5] = 1'b1;
    @(negedge clk) reset = 1'b1;
    v0 = n_valid;
    repeat (47) @(posedge clk); #1 check("hold_not_early", key_valid, 0);
    @(posedge clk);             #1 check("hold_event", key_valid, 1);
    check("hold_code", key_code, 5);
    wait_frames(10);
    check("hold_no_repeat", n_valid - v0, 1);
    check("hold_digit5", entry_bcd, 8'h05);
    @(negedge clk) pressed = '0;
    wait_frames(5);
    press_key(12);
    check("clr_cnt", entry_cnt, 0);

    // 4, 2, ENTER
    d0 = n_done;
    press_key(1); press_key(4); press_key(15);
    check("enter_value42", entry_value, 8'h42);
    check("enter_one_pulse", n_done - d0, 1);
    check("enter_bcd_clear", entry_bcd, 0);
    check("enter_cnt_clear", entry_cnt, 0);

    // 1, 2, 3 (third dropped), ENTER; then CLR, ENTER with nothing entered
    press_key(0); press_key(4); press_key(8);
    check("sat_bcd", entry_bcd, 8'h12);
    check("sat_cnt", entry_cnt, 2);
    press_key(15);
    check("sat_value12", entry_value, 8'h12);
    d0 = n_done;
    press_key(12); press_key(15);
    check("empty_enter_no_done", n_done - d0, 0);
    check("empty_enter_value", entry_value, 8'h12);

    // Two keys together (digits 0 and 5), then roll back to one key
    v0 = n_valid;
    @(negedge clk) pressed = '0; pressed[3] = 1'b1; pressed[5] = 1'b1;
    wait_frames(5);
    check("multi_set", multi_key, 1);
    @(negedge clk) pressed[5] = 1'b0;
    wait_frames(5);
    check("multi_clear", multi_key, 0);
    check("rollover_no_event", n_valid - v0, 0);
    @(negedge clk) pressed = '0;
    wait_frames(5);
    press_key(3);
    check("repress_event", n_valid - v0, 1);
    check("repress_code", key_code, 3);
    check("repress_cnt", entry_cnt, 1);

    // Bounce: key 10 toggles every frame
    v0 = n_valid;
    @(negedge clk) pressed = '0;
    for (int i = 0; i < 16; i++) begin
      pressed[10] = ~pressed[10];
      repeat (FRAME) @(negedge clk);
    end
    pressed = '0;
    wait_frames(5);
    check("bounce_no_event", n_valid - v0, 0);

    // Reset mid-frame with key 9 held
    @(negedge clk) pressed = '0; pressed[9] = 1'b1;
    repeat (FRAME + 6) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk) reset = 1'b1;
    repeat (48) @(posedge clk); #1 check("midrst_event", key_valid, 1);
    check("midrst_code", key_code, 9);
    @(negedge clk) pressed = '0;
    wait_frames(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_entry.md
Name: keypad_scan_entry

Overview:
- Parametrised matrix-keypad scanner with debounce, single-key event generation and a multi-digit BCD entry register.
- Drives one-hot column strobes, samples row sense lines and emits one-clock key events.
- Assembles digit keys into a DIGITS-wide BCD value, committed by the ENTER key.
- Sits between the board keypad pins and the display and control logic.

Parameters:
- COLS, 4, number of driven column lines.
- ROWS, 4, number of sensed row lines.
- TICK_DIV, 30000, clk cycles per scan step; 6 MHz gives 5 ms per column.
- DEBOUNCE, 3, consecutive identical frames required before the debounced image updates (>=1).
- DIGITS, 2, BCD digits held by the entry register (1..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_in  in  ROWS  row sense lines, active-high.
- key_out  out  COLS  one-hot column drive.
- key_valid  out  1  one-clk pulse on a debounced single-key press.
- key_code  out  CW=$clog2(ROWS*COLS)  code of the last event: row*COLS+col; holds its value between events.
- multi_key  out  1  high while the debounced image has 2 or more keys pressed.
- entry_bcd  out  4*DIGITS  live entry digits; least-significant digit in bits [3:0].
- entry_cnt  out  $clog2(DIGITS+1)  number of digits entered so far.
- entry_value  out  4*DIGITS  last committed value.
- entry_done  out  1  one-clk pulse when entry_value is loaded.

Behaviour:
- Reset values: key_out=1 (column 0). All other outputs 0. Divider, frame image, debounce counter and entry state are cleared.
- Tick: divider counts 0..TICK_DIV-1 and pulses tick when it wraps. All scan logic advances only on tick.
- Scan step (on tick):
  - Sample key_in into frame bits [col*ROWS +: ROWS] for the currently driven column.
  - Rotate key_out one-hot left; column COLS-1 wraps to column 0.
  - key_out never holds a non-one-hot value. An illegal state forces column 0 on the next tick.
- Frame end: the tick that samples column COLS-1.
  - If raw frame == previous raw frame, stable_cnt increments, saturating at DEBOUNCE. Otherwise stable_cnt=1.
  - When stable_cnt reaches DEBOUNCE, debounced image <= raw frame.
- Event generation, evaluated at the debounce update:
  - If the new image has exactly one key set, and the old image had no keys set: key_valid=1 for that one clk, and key_code=that key.
  - Two or more keys pressed: no event; multi_key=1.
  - Holding a key generates no repeat. All keys must release to empty before the next event.
  - Latency: a press that is stable from frame N produces an event at the end of frame N+DEBOUNCE-1.
- Key map (package constants, valid for the 4x4 default):
  - Digits 1..9 are codes 0,4,8,1,5,9,2,6,10; digit 0 is code 3.
  - KEY_CLR=12, KEY_ENTER=15. Codes 7, 11, 13 and 14 are reserved and produce an event only.
- Entry register, acting on the key_valid cycle:
  - Digit with entry_cnt<DIGITS: entry_bcd shifts left 4 bits, the new digit goes into [3:0], entry_cnt+1.
  - Digit with entry_cnt==DIGITS: ignored (entry saturates).
  - ENTER with entry_cnt>0: entry_value<=entry_bcd, entry_done pulses in the same clk as key_valid+1, then entry_bcd=0 and entry_cnt=0.
  - ENTER with entry_cnt==0: ignored; no pulse.
  - CLR: entry_bcd=0 and entry_cnt=0. entry_value is unchanged.
- Reset asserted mid-frame: everything returns to reset values immediately. Scanning restarts at column 0 with an empty image, so a held key produces a fresh event after DEBOUNCE full frames.

Decomposition:
- Package keypad_pkg holds:
  - KEY_CLR and KEY_ENTER.
  - Function key_to_digit(code) returning {is_digit, bcd}.
  - Default ROWS/COLS.
- One sub-module, keypad_debounce: frame compare, stable_cnt, debounced image, popcount and event detection.
- Divider, column rotation and the entry register remain in keypad_scan_entry.

Test Plan (TICK_DIV=4, DEBOUNCE=3, DIGITS=2):
- Reset release, no keys -> key_out sequence 0001,0010,0100,1000,0001, one step every 4 clk. No key_valid.
- Row 1 held high while column 1 is driven, for 4 frames -> a single key_valid with key_code=5 at the end of frame 3. Holding 10 more frames -> no further pulses.
- Press 4, release, press 2, release, press ENTER -> entry_value=8'h42 and entry_done a single pulse, then entry_bcd=0 and entry_cnt=0.
- Press 1,2,3 then ENTER -> the third digit is ignored, entry_value=8'h12. Then CLR followed by ENTER -> no entry_done.
- Keys 0 and 5 pressed together -> multi_key=1 and no key_valid. Release key 5 while keeping key 0 -> still no event until all keys release and key 0 is pressed again.
- Raw frame toggling every frame (bounce) -> no event. Reset asserted mid-frame with a key held -> key_out=0001, all outputs 0, event 3 frames after reset deasserts.
